// File: rtl/pll_mon_pkg.sv
// pll_mon_pkg
//   Shared definitions for the PLL lock supervisor:
//   - pll_state_e   : per-channel supervisor state (WAIT, SETTLE, LOCKED, RESET)
//   - timer_width() : width of the single per-channel cycle timer
//   - retry_width() : width of the per-channel auto-reset retry counter
package pll_mon_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2,
    ST_RESET  = 2'd3
  } pll_state_e;

  // One timer serves every state, so it must reach the largest terminal
  // count minus one.
  function automatic int timer_width(input int timeout_cycles,
                                     input int stable_cycles,
                                     input int rst_cycles);
    int m;
    m = timeout_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (rst_cycles > m) m = rst_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // The retry counter has to hold 0..max_retry; keep at least one bit so
  // a max_retry of 0 still yields a legal vector.
  function automatic int retry_width(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/pll_mon_chan.sv
// pll_mon_chan
//   Supervisor for one PLL: 2-FF lock synchroniser, WAIT/SETTLE/LOCKED/RESET
//   state machine with a shared cycle timer, bounded auto-reset retries,
//   sticky lost/timeout flags and a saturating loss counter.
// Ports
//   clk, rst       : system clock, synchronous active-high reset
//   pll_lock_i     : raw asynchronous lock from the PLL
//   clr_i          : one-cycle pulse clearing flags, loss count and retries
//   lost_o         : sticky, a qualified lock was lost
//   timeout_o      : sticky, WAIT timed out
//   loss_cnt_o     : saturating count of lost-lock events
//   state_o        : registered state; the parent decodes locked/reset from it
module pll_mon_chan
  import pll_mon_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RST_CYCLES     = 8,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock_i,
  input  logic             clr_i,
  output logic             lost_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] loss_cnt_o,
  output pll_state_e       state_o
);

  localparam int TW = timer_width(TIMEOUT_CYCLES, STABLE_CYCLES, RST_CYCLES);
  localparam int RW = retry_width(MAX_RETRY);

  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_LIMIT  = RW'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  logic             sync1_q, sync1_d;
  logic             sync_lock_q, sync_lock_d;
  pll_state_e       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  logic set_lost;
  logic set_timeout;
  logic inc_retry;

  always_comb begin
    sync1_d     = pll_lock_i;
    sync_lock_d = sync1_q;

    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    lost_d      = lost_q;
    timeout_d   = timeout_q;
    loss_cnt_d  = loss_cnt_q;
    set_lost    = 1'b0;
    set_timeout = 1'b0;
    inc_retry   = 1'b0;

    // Clear is applied first so that a simultaneous set event below wins.
    if (clr_i) begin
      lost_d     = 1'b0;
      timeout_d  = 1'b0;
      loss_cnt_d = '0;
      retry_d    = '0;
    end

    case (state_q)
      ST_WAIT: begin
        if (sync_lock_q) begin
          state_d = ST_SETTLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          // Out of retries: park here with the timer frozen at its terminal
          // value; the timeout flag keeps being re-asserted.
          set_timeout = 1'b1;
          if (retry_q < RETRY_LIMIT) begin
            state_d = ST_RESET;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!sync_lock_q) begin
          // Lock never qualified, so this is a glitch, not a loss.
          state_d = ST_WAIT;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!sync_lock_q) begin
          state_d  = ST_WAIT;
          timer_d  = '0;
          set_lost = 1'b1;
        end
      end
      ST_RESET: begin
        // Lock input is ignored while the PLL is held in reset.
        if (timer_q == RST_LAST) begin
          state_d   = ST_WAIT;
          timer_d   = '0;
          inc_retry = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
    endcase

    if (set_timeout) timeout_d = 1'b1;

    if (set_lost) begin
      lost_d  = 1'b1;
      retry_d = '0;
      if (clr_i) begin
        loss_cnt_d = CNT_W'(1);
      end else if (loss_cnt_q != CNT_MAX) begin
        loss_cnt_d = loss_cnt_q + 1'b1;
      end
    end

    // RESET is only entered with retry below the limit, so this cannot wrap.
    if (inc_retry) retry_d = retry_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync_lock_q <= 1'b0;
      state_q     <= ST_WAIT;
      timer_q     <= '0;
      retry_q     <= '0;
      lost_q      <= 1'b0;
      timeout_q   <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync_lock_q <= sync_lock_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      timeout_q   <= timeout_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign lost_o     = lost_q;
  assign timeout_o  = timeout_q;
  assign loss_cnt_o = loss_cnt_q;
  assign state_o    = state_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor
//   Lock supervisor for N_CH PLLs sharing one system clock. Each channel is
//   handled by a pll_mon_chan; this level decodes lock/reset from the
//   registered channel state and builds the summary outputs.
// Ports
//   clk, rst     : system clock, synchronous active-high reset
//   pll_lock_i   : raw asynchronous lock inputs, one per PLL
//   clr_i        : one-cycle pulse clearing sticky flags, counts, retries
//   locked_o     : qualified lock per channel
//   all_locked_o : AND of locked_o
//   lost_o       : sticky lost-after-qualified flags
//   timeout_o    : sticky WAIT timeout flags
//   pll_rst_o    : reset request to each PLL
//   loss_cnt_o   : saturating loss counts, channel i at [i*CNT_W +: CNT_W]
//   err_o        : OR of every lost_o and timeout_o bit
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RST_CYCLES     = 8,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       pll_lock_i,
  input  logic                  clr_i,
  output logic [N_CH-1:0]       locked_o,
  output logic                  all_locked_o,
  output logic [N_CH-1:0]       lost_o,
  output logic [N_CH-1:0]       timeout_o,
  output logic [N_CH-1:0]       pll_rst_o,
  output logic [N_CH*CNT_W-1:0] loss_cnt_o,
  output logic                  err_o
);

  pll_state_e chan_state [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    pll_mon_chan #(
      .STABLE_CYCLES  (STABLE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .RST_CYCLES     (RST_CYCLES),
      .MAX_RETRY      (MAX_RETRY),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .pll_lock_i (pll_lock_i[i]),
      .clr_i      (clr_i),
      .lost_o     (lost_o[i]),
      .timeout_o  (timeout_o[i]),
      .loss_cnt_o (loss_cnt_o[i*CNT_W +: CNT_W]),
      .state_o    (chan_state[i])
    );

    // Decoded from registered state, so both outputs are glitch-free.
    assign locked_o[i]  = (chan_state[i] == ST_LOCKED);
    assign pll_rst_o[i] = (chan_state[i] == ST_RESET);
  end

  assign all_locked_o = &locked_o;
  assign err_o        = (|lost_o) | (|timeout_o);

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor
//   Drives pll_lock_monitor with directed scenarios and randomized lock
//   waveforms. A cycle-level behavioural model predicts every output vector;
//   predictions go into exp_q and a monitor process compares them after each
//   rising edge. Directed scenarios add explicit constant checks.
module tb_pll_lock_monitor;

  localparam int N_CH    = 2;
  localparam int STABLE  = 16;
  localparam int TIMEOUT = 64;
  localparam int RSTC    = 4;
  localparam int MAXR    = 2;
  localparam int CNT_W   = 4;
  localparam int OW      = 4 * N_CH + 2 + N_CH * CNT_W;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  // Model phases: hunting for lock, qualifying, good lock, kicking the PLL.
  localparam int P_HUNT = 0;
  localparam int P_QUAL = 1;
  localparam int P_GOOD = 2;
  localparam int P_KICK = 3;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH-1:0]       pll_lock_i = '0;
  logic                  clr_i = 1'b0;
  logic [N_CH-1:0]       locked_o;
  logic                  all_locked_o;
  logic [N_CH-1:0]       lost_o;
  logic [N_CH-1:0]       timeout_o;
  logic [N_CH-1:0]       pll_rst_o;
  logic [N_CH*CNT_W-1:0] loss_cnt_o;
  logic                  err_o;

  always #5 clk = ~clk;

  pll_lock_monitor #(
    .N_CH           (N_CH),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .RST_CYCLES     (RSTC),
    .MAX_RETRY      (MAXR),
    .CNT_W          (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock_i   (pll_lock_i),
    .clr_i        (clr_i),
    .locked_o     (locked_o),
    .all_locked_o (all_locked_o),
    .lost_o       (lost_o),
    .timeout_o    (timeout_o),
    .pll_rst_o    (pll_rst_o),
    .loss_cnt_o   (loss_cnt_o),
    .err_o        (err_o)
  );

  // ---------------- reference model ----------------
  int m_s1     [N_CH];
  int m_s2     [N_CH];
  int m_phase  [N_CH];
  int m_age    [N_CH];
  int m_kicks  [N_CH];
  int m_lost   [N_CH];
  int m_tout   [N_CH];
  int m_losses [N_CH];

  task automatic model_step(input logic [N_CH-1:0] lk, input logic c, input logic r);
    for (int ch = 0; ch < N_CH; ch++) begin
      if (r) begin
        m_s1[ch] = 0; m_s2[ch] = 0; m_phase[ch] = P_HUNT; m_age[ch] = 0;
        m_kicks[ch] = 0; m_lost[ch] = 0; m_tout[ch] = 0; m_losses[ch] = 0;
      end else begin
        int  seen;
        int  nphase;
        int  nage;
        bit  drop;
        bit  tmo;
        bit  kicked;
        seen   = m_s2[ch];
        nphase = m_phase[ch];
        nage   = m_age[ch] + 1;
        drop   = 0;
        tmo    = 0;
        kicked = 0;
        case (m_phase[ch])
          P_HUNT: begin
            if (seen != 0) begin
              nphase = P_QUAL; nage = 0;
            end else if (m_age[ch] == TIMEOUT - 1) begin
              tmo = 1;
              if (m_kicks[ch] < MAXR) begin nphase = P_KICK; nage = 0; end
              else nage = m_age[ch];
            end
          end
          P_QUAL: begin
            if (seen == 0) begin nphase = P_HUNT; nage = 0; end
            else if (m_age[ch] == STABLE - 1) begin nphase = P_GOOD; nage = 0; end
          end
          P_GOOD: begin
            nage = 0;
            if (seen == 0) begin nphase = P_HUNT; drop = 1; end
          end
          default: begin
            if (m_age[ch] == RSTC - 1) begin nphase = P_HUNT; nage = 0; kicked = 1; end
          end
        endcase
        if (c) begin
          m_lost[ch] = 0; m_tout[ch] = 0; m_losses[ch] = 0; m_kicks[ch] = 0;
        end
        if (tmo) m_tout[ch] = 1;
        if (drop) begin
          m_lost[ch]  = 1;
          m_kicks[ch] = 0;
          if (m_losses[ch] < CNT_SAT) m_losses[ch]++;
        end
        if (kicked) m_kicks[ch]++;
        m_phase[ch] = nphase;
        m_age[ch]   = nage;
        m_s2[ch]    = m_s1[ch];
        m_s1[ch]    = int'(lk[ch]);
      end
    end
  endtask

  function automatic logic [OW-1:0] exp_vec();
    logic [N_CH-1:0]       lk, lo, to, pr;
    logic [N_CH*CNT_W-1:0] lc;
    for (int ch = 0; ch < N_CH; ch++) begin
      lk[ch] = (m_phase[ch] == P_GOOD);
      pr[ch] = (m_phase[ch] == P_KICK);
      lo[ch] = (m_lost[ch] != 0);
      to[ch] = (m_tout[ch] != 0);
      lc[ch*CNT_W +: CNT_W] = CNT_W'(m_losses[ch]);
    end
    return {(|lo) | (|to), lc, pr, to, lo, &lk, lk};
  endfunction

  function automatic logic [OW-1:0] dut_vec();
    return {err_o, loss_cnt_o, pll_rst_o, timeout_o, lost_o, all_locked_o, locked_o};
  endfunction

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [OW-1:0] e;
        logic [OW-1:0] g;
        e = exp_q.pop_front();
        g = dut_vec();
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL out_vec t=%0t got err=%b cnt=%h rst=%b to=%b lost=%b all=%b lk=%b exp err=%b cnt=%h rst=%b to=%b lost=%b all=%b lk=%b",
                   $time, g[OW-1], g[OW-2 -: N_CH*CNT_W], g[4*N_CH:3*N_CH+1], g[3*N_CH:2*N_CH+1],
                   g[2*N_CH:N_CH+1], g[N_CH], g[N_CH-1:0],
                   e[OW-1], e[OW-2 -: N_CH*CNT_W], e[4*N_CH:3*N_CH+1], e[3*N_CH:2*N_CH+1],
                   e[2*N_CH:N_CH+1], e[N_CH], e[N_CH-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [N_CH-1:0] lk, input logic c, input logic r);
    @(negedge clk);
    pll_lock_i = lk;
    clr_i      = c;
    rst        = r;
    model_step(lk, c, r);
    exp_q.push_back(exp_vec());
  endtask

  task automatic drive_n(input logic [N_CH-1:0] lk, input int n);
    for (int i = 0; i < n; i++) drive(lk, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(pll_lock_i, 1'b0, 1'b1);
  endtask

  // Wait for the edge of the last driven cycle and sample after it.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rises;
    int high;
    int first_rise;
    int second_rise;
    int seen_lock;
    logic prev;
    int run_left [N_CH];
    logic [N_CH-1:0] lvl;

    // Reset state.
    do_reset(3);
    settle();
    check("reset_outputs", int'(dut_vec()), 0);

    // Clean lock on ch0: sampled at edge k, qualified after edge k+18.
    drive_n(2'b01, 18);
    settle();
    check("clean_not_yet", int'(locked_o[0]), 0);
    drive_n(2'b01, 1);
    settle();
    check("clean_locked", int'(locked_o[0]), 1);
    check("clean_all_ch1_off", int'(all_locked_o), 0);
    drive_n(2'b11, 22);
    settle();
    check("clean_all_locked", int'(all_locked_o), 1);
    check("clean_no_loss", int'(loss_cnt_o), 0);
    check("clean_no_lost", int'(lost_o), 0);

    // Glitch during SETTLE.
    do_reset(2);
    seen_lock = 0;
    for (int i = 0; i < 35; i++) begin
      drive((i < 5) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      settle();
      if (locked_o[0]) seen_lock = 1;
    end
    check("glitch_never_locked", seen_lock, 0);
    check("glitch_no_lost", int'(lost_o[0]), 0);
    check("glitch_no_cnt", int'(loss_cnt_o[CNT_W-1:0]), 0);

    // Loss counting with random drop/relock lengths, then clear.
    do_reset(2);
    drive_n(2'b11, 25);
    for (int k = 0; k < 3; k++) begin
      drive_n(2'b10, $urandom_range(1, 4));
      drive_n(2'b11, $urandom_range(22, 30));
    end
    settle();
    check("loss_cnt_3", int'(loss_cnt_o[CNT_W-1:0]), 3);
    check("loss_lost", int'(lost_o[0]), 1);
    check("loss_err", int'(err_o), 1);
    drive(2'b11, 1'b1, 1'b0);
    settle();
    check("clr_cnt", int'(loss_cnt_o[CNT_W-1:0]), 0);
    check("clr_lost", int'(lost_o), 0);
    check("clr_err", int'(err_o), 0);
    check("clr_keeps_lock", int'(locked_o[0]), 1);

    // Timeout / retry on ch1 from reset release.
    do_reset(2);
    rises = 0; high = 0; first_rise = -1; second_rise = -1; prev = 1'b0;
    for (int i = 0; i < 260; i++) begin
      drive(2'b01, 1'b0, 1'b0);
      settle();
      if (pll_rst_o[1]) high++;
      if (pll_rst_o[1] && !prev) begin
        if (rises == 0) first_rise = i;
        if (rises == 1) second_rise = i;
        rises++;
      end
      prev = pll_rst_o[1];
    end
    check("retry_pulses", rises, MAXR);
    check("retry_high_cycles", high, MAXR * RSTC);
    check("retry_first_start", first_rise, TIMEOUT - 1);
    check("retry_second_start", second_rise, 2 * TIMEOUT + RSTC - 1);
    check("retry_timeout_flag", int'(timeout_o[1]), 1);
    check("retry_rst_low_end", int'(pll_rst_o[1]), 0);

    // Saturation, then clear colliding with a loss event.
    do_reset(2);
    drive_n(2'b11, 25);
    for (int k = 0; k < 20; k++) begin
      drive_n(2'b10, 2);
      drive_n(2'b11, 20);
    end
    settle();
    check("sat_cnt", int'(loss_cnt_o[CNT_W-1:0]), CNT_SAT);
    drive(2'b10, 1'b0, 1'b0);
    drive(2'b11, 1'b0, 1'b0);
    drive(2'b11, 1'b1, 1'b0);
    settle();
    check("prio_cnt", int'(loss_cnt_o[CNT_W-1:0]), 1);
    check("prio_lost", int'(lost_o[0]), 1);

    // Reset during SETTLE, then normal relock.
    do_reset(2);
    drive_n(2'b01, 8);
    drive(2'b01, 1'b0, 1'b1);
    settle();
    check("rst_settle_outputs", int'(dut_vec()), 0);
    drive_n(2'b01, 18);
    settle();
    check("relock_not_yet", int'(locked_o[0]), 0);
    drive_n(2'b01, 1);
    settle();
    check("relock_locked", int'(locked_o[0]), 1);

    // Reset during RESET state of ch1.
    do_reset(2);
    drive_n(2'b01, TIMEOUT + 2);
    settle();
    check("in_reset_state", int'(pll_rst_o[1]), 1);
    drive(2'b01, 1'b0, 1'b1);
    settle();
    check("rst_reset_outputs", int'(dut_vec()), 0);

    // Randomized lock waveforms with occasional clears and resets.
    do_reset(2);
    lvl = '0;
    for (int ch = 0; ch < N_CH; ch++) run_left[ch] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic c;
      logic r;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (run_left[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          if (lvl[ch]) run_left[ch] = int'($urandom_range(1, 45));
          else if ($urandom_range(0, 3) == 0) run_left[ch] = int'($urandom_range(60, 160));
          else run_left[ch] = int'($urandom_range(1, 20));
        end
        run_left[ch]--;
      end
      c = ($urandom_range(0, 63) == 0);
      r = ($urandom_range(0, 499) == 0);
      drive(lvl, c, r);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) settle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Synthesizable, parametrised PLL lock supervisor for N_CH PLL instances, all observed from one system clock. Per channel it synchronises the raw `pll_lock`, debounces it into a qualified lock, and records loss-of-lock events in sticky flags and a saturating counter. If a PLL never locks within a timeout, the block issues a bounded number of automatic PLL reset pulses. It sits beside the PLL IP instances and feeds system reset sequencing and status registers.

## Interface
- N_CH, 2: number of monitored PLLs (1..8).
- STABLE_CYCLES, 16: consecutive synchronised-high cycles required before a lock is qualified (≥2).
- TIMEOUT_CYCLES, 4096: cycles spent in WAIT before a timeout is declared (≥2).
- RST_CYCLES, 8: width of each `pll_rst_o` pulse (≥1).
- MAX_RETRY, 3: maximum automatic reset pulses per channel between clears (0 disables auto-reset).
- CNT_W, 8: loss counter width per channel.
- clk  in  1  system clock; one clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pll_lock_i  in  N_CH  raw, asynchronous lock inputs.
- clr_i  in  1  one-cycle pulse; clears sticky flags, loss counters and retry counters.
- locked_o  out  N_CH  qualified lock per channel.
- all_locked_o  out  1  AND of locked_o.
- lost_o  out  N_CH  sticky: lock dropped after being qualified.
- timeout_o  out  N_CH  sticky: WAIT timeout occurred.
- pll_rst_o  out  N_CH  reset request to the PLL, high while in RESET state.
- loss_cnt_o  out  N_CH*CNT_W  saturating loss counts, channel i at [i*CNT_W +: CNT_W].
- err_o  out  1  OR of all lost_o and timeout_o bits.

## Operation
- Each channel has a 2-FF synchroniser; the FSM uses only the second stage (sync_lock).
- A single shared-width cycle counter (timer) per channel serves all states; width = clog2 of max(TIMEOUT_CYCLES, STABLE_CYCLES, RST_CYCLES).
- States: WAIT, SETTLE, LOCKED, RESET. On entry to any state, timer = 0.
- WAIT: if sync_lock=1 → SETTLE. Else if timer = TIMEOUT_CYCLES-1: set timeout; if retry < MAX_RETRY → RESET; otherwise stay in WAIT with timer frozen. Else timer++.
- SETTLE: if sync_lock=0 → WAIT; this is a glitch, with no loss recorded. Else if timer = STABLE_CYCLES-1 → LOCKED. Else timer++.
- LOCKED: if sync_lock=0 → WAIT, set lost, loss_cnt++ (saturates at 2^CNT_W-1), retry = 0.
- RESET: pll_rst_o=1. When timer = RST_CYCLES-1 → WAIT and retry++. Lock input is ignored in this state.
- locked_o = (state==LOCKED); pll_rst_o = (state==RESET). Both are decoded from registered state, so they are glitch-free.
- clr_i clears lost, timeout, loss_cnt and retry. It does not change state or timer.
- If clr_i and a set event occur in the same cycle, the set wins: flag=1, loss_cnt=1.
- rst: all channels go to WAIT, timer=0, retry=0, sync FFs=0. Every output is 0 after reset.
- Reset mid-operation (e.g. in SETTLE or RESET) aborts immediately; pll_rst_o falls on the next edge.

## Timing
- pll_lock_i high at edge k and held → SETTLE after edge k+2, locked_o high after edge k+2+STABLE_CYCLES.
- pll_lock_i low at edge j while LOCKED → locked_o low, lost_o high and loss_cnt updated, all after edge j+2.
- Entry to WAIT at edge e with no lock → timeout_o and pll_rst_o rise after edge e+TIMEOUT_CYCLES. pll_rst_o stays high for exactly RST_CYCLES cycles, then WAIT restarts.
- all_locked_o and err_o are combinational from registered flags; they add no latency.

## Structure
- Package pll_mon_pkg holds the state enum (WAIT, SETTLE, LOCKED, RESET) and the timer-width function.
- Sub-module pll_mon_chan contains the per-channel synchroniser, FSM, timer, retry counter, flags and loss counter.
- pll_lock_monitor generate-instantiates N_CH pll_mon_chan instances and performs the reduction ORs/ANDs.

## Test plan
All scenarios use N_CH=2, STABLE_CYCLES=16, TIMEOUT_CYCLES=64, RST_CYCLES=4, MAX_RETRY=2, CNT_W=4.
- Clean lock: ch0 lock rises at edge 10 and is held → locked_o[0] rises after edge 28. all_locked_o stays 0 until ch1 is also qualified. lost_o=0, loss_cnt=0.
- Glitch: lock high for 5 cycles, then low during SETTLE → locked_o never rises, lost_o=0, loss_cnt=0, channel back in WAIT.
- Loss counting: qualified channel drops lock 3 times, relocking in between → loss_cnt=3, lost_o=1, err_o=1. A clr_i pulse then → all 0, and locked_o is unaffected.
- Timeout/retry: ch1 lock held low from rst release → pll_rst_o[1] pulses 4 cycles wide starting 64 cycles after each WAIT entry. Exactly 2 pulses occur, then ch1 stays in WAIT with timeout_o=1.
- Saturation and priority: 20 loss events → loss_cnt=15. clr_i asserted in the same cycle as a loss → loss_cnt=1, lost_o=1.
- Reset mid-operation: rst asserted during SETTLE and again during RESET → after the edge all outputs=0 and pll_rst_o=0. Normal lock is reached STABLE_CYCLES+2 cycles after lock is reapplied.
